// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (fetch and data), the shared
// arbiter, and a single-port RAM with a combinational read path.
interface mem_arbiter_if;
    // fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    // data port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    // RAM side
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic [31:0] mem_rd;
    // status
    logic        busy;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rd,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_a, mem_wd, mem_be, mem_we, busy
    );

    // Environment view: requesters plus the RAM
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rd,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_a, mem_wd, mem_be, mem_we, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each transaction is IDLE/RESP (grant) -> ACCESS (RAM cycle) -> RESP (ack).
// A waiting request on the other port is granted straight from RESP, so
// back-to-back traffic completes one transaction every two cycles.
module mem_arbiter #(
    parameter int MEM_WORDS = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t      state;
    port_t       owner;
    port_t       last_grant;

    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        mem_we_q;
    logic        busy_q;

    logic        i_ack_q, i_err_q, d_ack_q, d_err_q;
    logic [31:0] i_rdata_q, d_rdata_q;

    logic        take;
    logic        sel_d;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_wd;
    logic [3:0]  nxt_be;
    logic        nxt_we;

    // Word address must sit in the low 4 KiB and below the populated size.
    function automatic logic in_range(input logic [31:0] a);
        return (a[31:12] == 20'd0) && ({22'd0, a[11:2]} < MEM_WORDS);
    endfunction

    // Grant decision: round-robin from IDLE, other port only from RESP.
    always_comb begin
        take  = 1'b0;
        sel_d = 1'b0;
        case (state)
            IDLE: begin
                take  = bus.i_req | bus.d_req;
                sel_d = bus.d_req & (~bus.i_req | (last_grant == PORT_I));
            end
            RESP: begin
                if (owner == PORT_I) begin
                    take  = bus.d_req;
                    sel_d = 1'b1;
                end else begin
                    take  = bus.i_req;
                    sel_d = 1'b0;
                end
            end
            default: begin
                take  = 1'b0;
                sel_d = 1'b0;
            end
        endcase
        nxt_addr = sel_d ? bus.d_addr  : bus.i_addr;
        nxt_wd   = sel_d ? bus.d_wdata : 32'd0;
        nxt_be   = sel_d ? bus.d_be    : 4'b0000;
        nxt_we   = sel_d & bus.d_we;
    end

    // Arbiter FSM with registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= PORT_I;
            last_grant <= PORT_I;
            addr_q     <= 32'd0;
            wd_q       <= 32'd0;
            be_q       <= 4'b0000;
            we_q       <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            i_ack_q    <= 1'b0;
            i_err_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            i_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    i_ack_q <= 1'b0;
                    i_err_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    d_err_q <= 1'b0;
                    if (take) begin
                        addr_q     <= nxt_addr;
                        wd_q       <= nxt_wd;
                        be_q       <= nxt_be;
                        we_q       <= nxt_we;
                        owner      <= sel_d ? PORT_D : PORT_I;
                        last_grant <= sel_d ? PORT_D : PORT_I;
                        mem_we_q   <= nxt_we & in_range(nxt_addr);
                        busy_q     <= 1'b1;
                        state      <= ACCESS;
                    end else begin
                        mem_we_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b1;
                    state    <= RESP;
                    if (owner == PORT_D) begin
                        d_ack_q   <= 1'b1;
                        d_err_q   <= ~in_range(addr_q);
                        d_rdata_q <= in_range(addr_q) ? bus.mem_rd : 32'd0;
                    end else begin
                        i_ack_q   <= 1'b1;
                        i_err_q   <= ~in_range(addr_q);
                        i_rdata_q <= in_range(addr_q) ? bus.mem_rd : 32'd0;
                    end
                end
                default: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_a   = addr_q;
    assign bus.mem_wd  = wd_q;
    assign bus.mem_be  = be_q;
    assign bus.mem_we  = mem_we_q;
    assign bus.busy    = busy_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.i_err   = i_err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-enabled RAM model.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   we_snap;

    logic [31:0] ram [0:1023];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_val;

    logic [31:0] a_acc, wd_acc, be_acc, we_acc, ack_r, err_r, rd_r, ack_post, busy_post;

    mem_arbiter_if bus();

    mem_arbiter #(.MEM_WORDS(1023)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rd = ram[bus.mem_a[11:2]];

    // RAM: preload port for the bench, otherwise byte-enabled writes
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_idx] <= pl_val;
        end else if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) ram[bus.mem_a[11:2]][8*b +: 8] <= bus.mem_wd[8*b +: 8];
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        step();
        pl_en  = 1'b0;
    endtask

    // One data-port transaction from IDLE: captures ACCESS and RESP views.
    task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd; bus.d_be = be;
        step();
        a_acc  = bus.mem_a;  wd_acc = bus.mem_wd;
        be_acc = 32'(bus.mem_be); we_acc = 32'(bus.mem_we);
        step();
        ack_r = 32'(bus.d_ack); err_r = 32'(bus.d_err); rd_r = bus.d_rdata;
        bus.d_req = 1'b0;
        step();
        ack_post = 32'(bus.d_ack); busy_post = 32'(bus.busy);
    endtask

    initial begin
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;

        // asynchronous reset before any clock edge
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_acks",   {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
        chk("rst_errs",   {30'd0, bus.i_err, bus.d_err}, 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_a",  bus.mem_a,       32'd0);
        chk("rst_mem_wd", bus.mem_wd,      32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_rdata",  bus.i_rdata | bus.d_rdata, 32'd0);

        preload(10'd4,    32'hDEADBEEF);
        preload(10'd8,    32'hAABBCCDD);
        preload(10'd9,    32'h00000055);
        preload(10'd1023, 32'h12345678);
        preload(10'd0,    32'hCAFEF00D);
        preload(10'd12,   32'h01010101);
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // fetch alone
        we_snap = we_cnt;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        step();
        chk("f_busy",   32'(bus.busy),  32'd1);
        chk("f_mem_a",  bus.mem_a,      32'h10);
        chk("f_ack_c2", 32'(bus.i_ack), 32'd0);
        step();
        chk("f_ack",    32'(bus.i_ack), 32'd1);
        chk("f_rdata",  bus.i_rdata,    32'hDEADBEEF);
        chk("f_err",    32'(bus.i_err), 32'd0);
        bus.i_req = 1'b0;
        step();
        chk("f_ack_off", 32'(bus.i_ack), 32'd0);
        chk("f_idle",    32'(bus.busy),  32'd0);
        chk("f_no_we",   32'(we_cnt - we_snap), 32'd0);

        // partial store
        we_snap = we_cnt;
        d_txn(1'b1, 32'h20, 32'h11223344, 4'b0011);
        chk("s_mem_we", we_acc, 32'd1);
        chk("s_mem_a",  a_acc,  32'h20);
        chk("s_mem_be", be_acc, 32'h3);
        chk("s_mem_wd", wd_acc, 32'h11223344);
        chk("s_ack",    ack_r,  32'd1);
        chk("s_err",    err_r,  32'd0);
        chk("s_we_cnt", 32'(we_cnt - we_snap), 32'd1);
        chk("s_ram",    ram[8], 32'hAABB3344);
        chk("s_ack_off", ack_post, 32'd0);

        // both ports from reset: D,I,D,I
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h24; bus.d_wdata = '0; bus.d_be = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("rr_busy_%0d", k), 32'(bus.busy), 32'd1);
            if (k % 2 == 0) begin
                chk($sformatf("rr_dack_%0d", k), 32'(bus.d_ack), (k == 2 || k == 6) ? 32'd1 : 32'd0);
                chk($sformatf("rr_iack_%0d", k), 32'(bus.i_ack), (k == 4 || k == 8) ? 32'd1 : 32'd0);
            end else begin
                chk($sformatf("rr_grant_%0d", k), bus.mem_a, (k == 1 || k == 5) ? 32'h24 : 32'h10);
            end
            if (k == 2) chk("rr_drdata", bus.d_rdata, 32'h55);
            if (k == 4) chk("rr_irdata", bus.i_rdata, 32'hDEADBEEF);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        step();
        chk("rr_idle", 32'(bus.busy), 32'd0);

        // out-of-range loads
        we_snap = we_cnt;
        d_txn(1'b0, 32'hFFC, 32'd0, 4'b0000);
        chk("oob1_we",    we_acc, 32'd0);
        chk("oob1_ack",   ack_r,  32'd1);
        chk("oob1_err",   err_r,  32'd1);
        chk("oob1_rdata", rd_r,   32'd0);
        d_txn(1'b0, 32'h1000, 32'd0, 4'b0000);
        chk("oob2_we",    we_acc, 32'd0);
        chk("oob2_ack",   ack_r,  32'd1);
        chk("oob2_err",   err_r,  32'd1);
        chk("oob2_rdata", rd_r,   32'd0);
        chk("oob2_errpost", 32'(bus.d_err), 32'd0);

        // dump-trigger store
        d_txn(1'b1, 32'hFFFFFFFF, 32'h99, 4'b1111);
        chk("dump_mem_a", a_acc, 32'hFFFFFFFF);
        chk("dump_we",    we_acc, 32'd0);
        chk("dump_ack",   ack_r,  32'd1);
        chk("dump_err",   err_r,  32'd1);
        chk("oob_no_we",  32'(we_cnt - we_snap), 32'd0);

        // zero byte-enable store still completes
        d_txn(1'b1, 32'h24, 32'hFFFFFFFF, 4'b0000);
        chk("be0_we",  we_acc, 32'd1);
        chk("be0_ack", ack_r,  32'd1);
        chk("be0_err", err_r,  32'd0);
        chk("be0_ram", ram[9], 32'h00000055);

        // reset in the middle of a store's ACCESS cycle
        we_snap = we_cnt;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30; bus.d_wdata = 32'h77777777; bus.d_be = 4'b1111;
        step();
        chk("mid_we_on", 32'(bus.mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_we_off", 32'(bus.mem_we), 32'd0);
        chk("mid_busy",   32'(bus.busy),   32'd0);
        bus.d_req = 1'b0;
        step();
        chk("mid_no_ack1", 32'(bus.d_ack), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mid_no_ack2", 32'(bus.d_ack), 32'd0);
        chk("mid_idle",    32'(bus.busy),  32'd0);
        chk("mid_ram",     ram[12],        32'h01010101);
        chk("mid_we_cnt",  32'(we_cnt - we_snap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
